// File: rtl/sd_crc_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : sd_crc_pkg                                                       |
// | Brief   : Shared types, constants and CRC16 step function for SD DAT CRC. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package sd_crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;
  localparam logic        MODE_RX    = 1'b0;
  localparam logic        MODE_TX    = 1'b1;

  // One serial CRC16 step with the data bit folded into the feedback.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ (((din ^ crc[15]) == 1'b1) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc16_lane.sv
// +----------------------------------------------------------------------------+
// | Module  : crc16_lane                                                       |
// | Brief   : One serial CRC16 register: clear, data update or CRC shift-out. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module crc16_lane
  import sd_crc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        update,
  input  logic        din,
  input  logic        shift,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= CRC16_INIT;
    end else if (clear) begin
      r_crc <= CRC16_INIT;
    end else if (update) begin
      r_crc <= crc16_step(r_crc, din);
    end else if (shift) begin
      r_crc <= {r_crc[14:0], 1'b0};
    end
  end

  assign crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/sd_dat_crc16.sv
// +----------------------------------------------------------------------------+
// | Module  : sd_dat_crc16                                                     |
// | Brief   : Multi-lane SD DAT CRC16 generator/checker; optional error count |
// |           output enabled by macro SD_CRC_ERRCNT_EN.                        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sd_dat_crc16
  import sd_crc_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int BLEN_W = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [BLEN_W-1:0]     blklen,
  input  logic                  abort,
  input  logic                  bit_en,
  input  logic [LANES-1:0]      din,
  output logic [LANES-1:0]      dout,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_ok,
  output logic [LANES-1:0]      crc_err,
  output logic [16*LANES-1:0]   crc_val
`ifdef SD_CRC_ERRCNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_mode;
  logic [BLEN_W-1:0]       r_blklen;
  logic [BLEN_W-1:0]       r_cnt;
  logic [LANES-1:0][15:0]  w_lane_crc;
  logic [LANES-1:0][15:0]  w_upd_crc;
  logic [LANES-1:0][15:0]  r_crc_val;
  logic [LANES-1:0]        w_msb;
  logic [LANES-1:0]        r_crc_err;
  logic [LANES-1:0]        w_err_nxt;
  logic                    r_crc_ok;
  logic                    w_accept;
  logic                    w_upd;
  logic                    w_shift;
  logic                    w_data_last;
  logic                    w_crc_last;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    crc16_lane u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (w_accept),
      .update (w_upd),
      .din    (din[n]),
      .shift  (w_shift),
      .crc    (w_lane_crc[n])
    );
    assign w_msb[n]     = w_lane_crc[n][15];
    assign w_upd_crc[n] = crc16_step(w_lane_crc[n], din[n]);
  end

  // Abort gates every datapath strobe so it wins over START and BIT_EN.
  always_comb begin
    w_accept    = (r_state == IDLE) && start && (blklen != '0) && !abort;
    w_upd       = (r_state == DATA) && bit_en && !abort;
    w_shift     = (r_state == CRC) && bit_en && !abort;
    w_data_last = w_upd && (r_cnt == (r_blklen - BLEN_W'(1)));
    w_crc_last  = w_shift && (r_cnt == BLEN_W'(15));
    w_err_nxt   = r_crc_err;
    if (w_shift && (r_mode == MODE_RX)) begin
      w_err_nxt = r_crc_err | (din ^ w_msb);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept)    w_state_nxt = DATA;
        DATA:    if (w_data_last) w_state_nxt = CRC;
        CRC:     if (w_crc_last)  w_state_nxt = DONE;
        DONE:                     w_state_nxt = IDLE;
        default:                  w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode    <= MODE_RX;
      r_blklen  <= '0;
      r_cnt     <= '0;
      r_crc_val <= '0;
      r_crc_err <= '0;
      r_crc_ok  <= 1'b0;
    end else if (abort) begin
      r_crc_err <= '0;
      r_crc_ok  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode    <= mode;
        r_blklen  <= blklen;
        r_cnt     <= '0;
        r_crc_err <= '0;
        r_crc_ok  <= 1'b0;
      end
      if (w_upd) begin
        r_cnt <= w_data_last ? '0 : r_cnt + BLEN_W'(1);
        if (w_data_last) begin
          r_crc_val <= w_upd_crc;
        end
      end
      if (w_shift) begin
        r_cnt     <= r_cnt + BLEN_W'(1);
        r_crc_err <= w_err_nxt;
      end
      // Result is registered on entry to DONE so it is valid alongside the pulse.
      if (w_crc_last) begin
        r_crc_ok <= r_mode | ~|w_err_nxt;
      end
    end
  end

`ifdef SD_CRC_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= 8'd0;
    end else if (!abort && w_crc_last && (r_mode == MODE_RX) && (|w_err_nxt)
                 && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  always_comb begin
    dout = '1;
    if (r_mode == MODE_TX) begin
      case (r_state)
        DATA:    dout = din;
        CRC:     dout = w_msb;
        default: dout = '1;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign crc_ok  = r_crc_ok;
  assign crc_err = r_crc_err;
  assign crc_val = r_crc_val;

endmodule

`default_nettype wire

// File: tb/tb_sd_dat_crc16.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_sd_dat_crc16                                                  |
// | Brief   : Table-driven self-checking bench for sd_dat_crc16 (LANES=4).    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sd_dat_crc16;

  localparam int LANES  = 4;
  localparam int BLEN_W = 13;

  typedef struct {
    logic             mode;
    int               blen;
    int               pat;     // 0 ones, 1 ascii "123456789", 2 random, 3 reuse
    int               gapmax;
    int               clane;   // lane whose CRC bit is inverted, -1 none
    int               cbit;
    logic             exp_ok;
    logic [LANES-1:0] exp_err;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  start = 1'b0;
  logic                  mode = 1'b0;
  logic [BLEN_W-1:0]     blklen = '0;
  logic                  abort = 1'b0;
  logic                  bit_en = 1'b0;
  logic [LANES-1:0]      din = '0;
  logic [LANES-1:0]      dout;
  logic                  busy;
  logic                  done;
  logic                  crc_ok;
  logic [LANES-1:0]      crc_err;
  logic [16*LANES-1:0]   crc_val;
`ifdef SD_CRC_ERRCNT_EN
  logic [7:0]            err_cnt;
  int                    exp_errcnt = 0;
`endif

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  logic [LANES-1:0] dmem [4096];
  vec_t vecs [9];

  sd_dat_crc16 #(.LANES(LANES), .BLEN_W(BLEN_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .mode   (mode),
    .blklen (blklen),
    .abort  (abort),
    .bit_en (bit_en),
    .din    (din),
    .dout   (dout),
    .busy   (busy),
    .done   (done),
    .crc_ok (crc_ok),
    .crc_err(crc_err),
`ifdef SD_CRC_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .crc_val(crc_val)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    c = {c[14:0], 1'b0};
    if (fb) c = c ^ 16'h1021;
    return c;
  endfunction

  task automatic fill(input int pat, input int len);
    string s = "123456789";
    logic [7:0] ch;
    if (pat == 3) return;
    for (int i = 0; i < len; i++) begin
      if (pat == 0) dmem[i] = '1;
      else if (pat == 1) begin
        ch = s[i/8];
        dmem[i] = {LANES{ch[7 - (i % 8)]}};
      end else dmem[i] = LANES'($urandom);
    end
  endtask

  task automatic gaps(input int gapmax);
    repeat ($urandom_range(0, gapmax)) begin
      bit_en = 1'b0;
      din = LANES'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [LANES-1:0][15:0] exp_crc;
    logic [LANES-1:0]       bits;
    logic [15:0]            c;
    int                     dbad;
    int                     d0;
    dbad = 0;
    d0 = done_cnt;
    fill(v.pat, v.blen);
    for (int n = 0; n < LANES; n++) begin
      c = 16'h0000;
      for (int i = 0; i < v.blen; i++) c = step(c, dmem[i][n]);
      exp_crc[n] = c;
    end
    @(negedge clk);
    start = 1'b1; mode = v.mode; blklen = BLEN_W'(v.blen);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_start"}, 64'(busy), 64'd1);
    for (int i = 0; i < v.blen; i++) begin
      gaps(v.gapmax);
      // a second START with the opposite mode must be ignored while busy
      start = (i == 0); mode = ~v.mode; blklen = BLEN_W'(1);
      bit_en = 1'b1; din = dmem[i];
      #1;
      if (v.mode && dout !== din) dbad++;
      @(negedge clk);
    end
    bit_en = 1'b0; start = 1'b0;
    chk({tag, " crc_val"}, 64'(crc_val), 64'(exp_crc));
    for (int k = 0; k < 16; k++) begin
      gaps(v.gapmax);
      for (int n = 0; n < LANES; n++)
        bits[n] = exp_crc[n][15-k] ^ ((n == v.clane) && ((15 - k) == v.cbit));
      bit_en = 1'b1; din = bits;
      #1;
      for (int n = 0; n < LANES; n++)
        if (v.mode && dout[n] !== exp_crc[n][15-k]) dbad++;
      @(negedge clk);
    end
    bit_en = 1'b0;
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " dout_done"}, 64'(dout), 64'({LANES{1'b1}}));
    chk({tag, " crc_ok"}, 64'(crc_ok), 64'(v.exp_ok));
    chk({tag, " crc_err"}, 64'(crc_err), 64'(v.exp_err));
    if (v.pat == 1) chk({tag, " crc_ascii"}, 64'(crc_val[15:0]), 64'h31C3);
`ifdef SD_CRC_ERRCNT_EN
    if (!v.mode && !v.exp_ok && exp_errcnt < 255) exp_errcnt++;
    chk({tag, " err_cnt"}, 64'(err_cnt), 64'(exp_errcnt));
`endif
    @(negedge clk);
    chk({tag, " done_low"}, 64'(done), 64'd0);
    chk({tag, " busy_end"}, 64'(busy), 64'd0);
    chk({tag, " done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, " hold_ok"}, 64'(crc_ok), 64'(v.exp_ok));
    if (v.mode) chk({tag, " dout_seq_errs"}, 64'(dbad), 64'd0);
  endtask

  initial begin
    int d0;
    vecs[0] = '{1'b1, 4096, 0, 0, -1, 0, 1'b1, 4'b0000};
    vecs[1] = '{1'b0,   72, 1, 0, -1, 0, 1'b1, 4'b0000};
    vecs[2] = '{1'b0, 1024, 2, 0,  2, 5, 1'b0, 4'b0100};
    vecs[3] = '{1'b1, 1024, 2, 7, -1, 0, 1'b1, 4'b0000};
    vecs[4] = '{1'b1, 1024, 3, 0, -1, 0, 1'b1, 4'b0000};
    vecs[5] = '{1'b0,   40, 2, 3,  0, 15, 1'b0, 4'b0001};
    vecs[6] = '{1'b0,    1, 2, 0,  3, 0, 1'b0, 4'b1000};
    vecs[7] = '{1'b0,   16, 2, 2, -1, 0, 1'b1, 4'b0000};
    vecs[8] = '{1'b1,    8, 2, 0,  1, 3, 1'b1, 4'b0000};

    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst crc_ok", 64'(crc_ok), 64'd0);
    chk("rst crc_err", 64'(crc_err), 64'd0);
    chk("rst crc_val", 64'(crc_val), 64'd0);
    chk("rst dout", 64'(dout), 64'hF);
`ifdef SD_CRC_ERRCNT_EN
    chk("rst err_cnt", 64'(err_cnt), 64'd0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // abort on data strobe 100, then a clean block on the same data
    fill(2, 200);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; blklen = BLEN_W'(200);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bit_en = 1'b1; din = dmem[i]; @(negedge clk);
    end
    bit_en = 1'b1; abort = 1'b1; din = dmem[100];
    @(negedge clk);
    abort = 1'b0; bit_en = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort crc_ok", 64'(crc_ok), 64'd0);
    chk("abort crc_err", 64'(crc_err), 64'd0);
    repeat (20) begin
      bit_en = 1'b1; din = '1; @(negedge clk);
    end
    bit_en = 1'b0;
    chk("abort stays idle", 64'(busy), 64'd0);
    chk("abort no done", 64'(done_cnt - d0), 64'd0);
    run_vec('{1'b0, 200, 3, 1, -1, 0, 1'b1, 4'b0000}, "post_abort");

    // asynchronous reset during the CRC phase
    fill(2, 8);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; blklen = BLEN_W'(8);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bit_en = 1'b1; din = dmem[i % 8]; @(negedge clk);
    end
    bit_en = 1'b0;
    chk("pre_rst busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst busy", 64'(busy), 64'd0);
    chk("mid_rst done", 64'(done), 64'd0);
    chk("mid_rst crc_ok", 64'(crc_ok), 64'd0);
    chk("mid_rst crc_err", 64'(crc_err), 64'd0);
    chk("mid_rst crc_val", 64'(crc_val), 64'd0);
    chk("mid_rst dout", 64'(dout), 64'hF);
`ifdef SD_CRC_ERRCNT_EN
    exp_errcnt = 0;
    chk("mid_rst err_cnt", 64'(err_cnt), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; blklen = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_len busy", 64'(busy), 64'd0);
    repeat (3) begin
      bit_en = 1'b1; din = '0; @(negedge clk);
    end
    bit_en = 1'b0;
    chk("zero_len still idle", 64'(busy), 64'd0);
    chk("zero_len dout", 64'(dout), 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
